watch_set_ctrl: RTL and testbench



---
 rtl/watch_set_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_watch_set_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/watch_set_ctrl.sv
// Watch time-setting controller: button debounce, RUN/SET_HOUR/SET_MIN mode FSM,
// increment/clear pulses and display select/blink. Define AUTOREPEAT_EN for INC auto-repeat.
module watch_set_ctrl #(
  parameter int unsigned DEBOUNCE_CYC = 16,
  parameter int unsigned TIMEOUT_S    = 30,
  parameter int unsigned REPEAT_DLY_S = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       tick_i,
  input  logic       mode_btn_i,
  input  logic       inc_btn_i,
  output logic       run_o,
  output logic       inc_hour_o,
  output logic       inc_min_o,
  output logic       clr_sec_o,
  output logic [1:0] sel_o,
  output logic       blink_o
);

  if (DEBOUNCE_CYC < 2) begin : g_bad_debounce
    $error("DEBOUNCE_CYC must be at least 2");
  end
  if (TIMEOUT_S < 1) begin : g_bad_timeout
    $error("TIMEOUT_S must be at least 1");
  end
  if (REPEAT_DLY_S < 1) begin : g_bad_repeat
    $error("REPEAT_DLY_S must be at least 1");
  end

  localparam int unsigned DbW = $clog2(DEBOUNCE_CYC);
  localparam int unsigned ToW = $clog2(TIMEOUT_S + 1);
  localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYC - 1);
  localparam logic [ToW-1:0] ToMax  = ToW'(TIMEOUT_S);

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StSetHour = 2'd1,
    StSetMin  = 2'd2
  } state_e;

  // Bit 0 = MODE, bit 1 = INC
  logic [1:0]     raw;
  logic [1:0]     deb_q, deb_d, deb_prev_q;
  logic [DbW-1:0] db_cnt_q [2];
  logic [DbW-1:0] db_cnt_d [2];

  assign raw = {inc_btn_i, mode_btn_i};

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      deb_d[i]    = deb_q[i];
      db_cnt_d[i] = '0;
      if (raw[i] != deb_q[i]) begin
        if (db_cnt_q[i] == DbLast) begin
          deb_d[i] = raw[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  logic mode_press, inc_press;
  assign mode_press = deb_q[0] & ~deb_prev_q[0];
  assign inc_press  = deb_q[1] & ~deb_prev_q[1];

  state_e         state_q, state_d;
  logic [ToW-1:0] to_q, to_d;
  logic           run_q, run_d;
  logic [1:0]     sel_q, sel_d;
  logic           blink_q, blink_d;
  logic           inc_hour_q, inc_hour_d;
  logic           inc_min_q, inc_min_d;
  logic           clr_sec_q, clr_sec_d;
  logic           set_mode, inc_evt, rep_fire;

  assign set_mode = (state_q != StRun);

`ifdef AUTOREPEAT_EN
  localparam int unsigned RpW = $clog2(REPEAT_DLY_S + 1);
  localparam logic [RpW-1:0] RpMax = RpW'(REPEAT_DLY_S);

  logic [RpW-1:0] rep_q, rep_d;

  // Once the hold delay has elapsed every further tick fires one repeat pulse
  assign rep_fire = set_mode & deb_q[1] & tick_i & (rep_q == RpMax);

  always_comb begin
    rep_d = rep_q;
    if (!set_mode || !deb_q[1] || (state_d != state_q)) begin
      rep_d = '0;
    end else if (tick_i && (rep_q != RpMax)) begin
      rep_d = rep_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rep_q <= '0;
    end else begin
      rep_q <= rep_d;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  // MODE beats INC when both land in the same cycle
  assign inc_evt = set_mode & ~mode_press & (inc_press | rep_fire);

  always_comb begin
    state_d    = state_q;
    clr_sec_d  = 1'b0;
    inc_hour_d = 1'b0;
    inc_min_d  = 1'b0;
    blink_d    = blink_q;
    to_d       = to_q;
    sel_d      = 2'b00;

    unique case (state_q)
      StRun: begin
        if (mode_press) state_d = StSetHour;
      end
      StSetHour: begin
        if (mode_press) begin
          state_d = StSetMin;
        end else if ((to_q == ToMax) && !inc_evt) begin
          state_d = StRun;
        end
      end
      StSetMin: begin
        if (mode_press) begin
          state_d   = StRun;
          clr_sec_d = 1'b1;
        end else if ((to_q == ToMax) && !inc_evt) begin
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase

    if (inc_evt) begin
      if (state_q == StSetHour) begin
        inc_hour_d = 1'b1;
      end else begin
        inc_min_d = 1'b1;
      end
    end

    if (state_d == StRun) begin
      blink_d = 1'b0;
    end else if ((state_d != state_q) || inc_evt) begin
      blink_d = 1'b1;
    end else if (tick_i) begin
      blink_d = ~blink_q;
    end

    if ((state_d == StRun) || (state_d != state_q) || mode_press || inc_press || rep_fire) begin
      to_d = '0;
    end else if (tick_i && (to_q != ToMax)) begin
      to_d = to_q + 1'b1;
    end

    unique case (state_d)
      StSetHour: sel_d = 2'b01;
      StSetMin:  sel_d = 2'b10;
      default:   sel_d = 2'b00;
    endcase
    run_d = (state_d == StRun);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      deb_q       <= '0;
      deb_prev_q  <= '0;
      db_cnt_q[0] <= '0;
      db_cnt_q[1] <= '0;
      state_q     <= StRun;
      to_q        <= '0;
      run_q       <= 1'b1;
      sel_q       <= 2'b00;
      blink_q     <= 1'b0;
      inc_hour_q  <= 1'b0;
      inc_min_q   <= 1'b0;
      clr_sec_q   <= 1'b0;
    end else begin
      deb_q       <= deb_d;
      deb_prev_q  <= deb_q;
      db_cnt_q[0] <= db_cnt_d[0];
      db_cnt_q[1] <= db_cnt_d[1];
      state_q     <= state_d;
      to_q        <= to_d;
      run_q       <= run_d;
      sel_q       <= sel_d;
      blink_q     <= blink_d;
      inc_hour_q  <= inc_hour_d;
      inc_min_q   <= inc_min_d;
      clr_sec_q   <= clr_sec_d;
    end
  end

  assign run_o      = run_q;
  assign sel_o      = sel_q;
  assign blink_o    = blink_q;
  assign inc_hour_o = inc_hour_q;
  assign inc_min_o  = inc_min_q;
  assign clr_sec_o  = clr_sec_q;

endmodule

// File: tb/tb_watch_set_ctrl.sv
// Directed self-checking bench for watch_set_ctrl (DEBOUNCE_CYC=4, TIMEOUT_S=5, REPEAT_DLY_S=2).
module tb_watch_set_ctrl;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       tick_i = 1'b0;
  logic       mode_btn_i = 1'b0;
  logic       inc_btn_i = 1'b0;
  logic       run_o, inc_hour_o, inc_min_o, clr_sec_o, blink_o;
  logic [1:0] sel_o;

  int n_cmp = 0;
  int n_bad = 0;
  int n_hour = 0, n_min = 0, n_clr = 0, n_multi = 0;
  int h0, m0, c0;

  always #5 clk = ~clk;

  watch_set_ctrl #(
    .DEBOUNCE_CYC (4),
    .TIMEOUT_S    (5),
    .REPEAT_DLY_S (2)
  ) u_dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .tick_i     (tick_i),
    .mode_btn_i (mode_btn_i),
    .inc_btn_i  (inc_btn_i),
    .run_o      (run_o),
    .inc_hour_o (inc_hour_o),
    .inc_min_o  (inc_min_o),
    .clr_sec_o  (clr_sec_o),
    .sel_o      (sel_o),
    .blink_o    (blink_o)
  );

  // Cycles each pulse output is high, plus cycles with more than one pulse high
  always @(negedge clk) begin
    if (inc_hour_o === 1'b1) n_hour++;
    if (inc_min_o === 1'b1) n_min++;
    if (clr_sec_o === 1'b1) n_clr++;
    if (((inc_hour_o === 1'b1) ? 1 : 0) + ((inc_min_o === 1'b1) ? 1 : 0)
        + ((clr_sec_o === 1'b1) ? 1 : 0) > 1) n_multi++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick1();
    tick_i = 1'b1;
    cyc(1);
    tick_i = 1'b0;
    cyc(1);
  endtask

  task automatic press_mode();
    mode_btn_i = 1'b1;
    cyc(6);
    mode_btn_i = 1'b0;
    cyc(6);
  endtask

  task automatic press_inc();
    inc_btn_i = 1'b1;
    cyc(6);
    inc_btn_i = 1'b0;
    cyc(6);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    cyc(3);
    rst_i = 1'b0;
    cyc(1);
    check_eq("rst_run", run_o, 1);
    check_eq("rst_sel", sel_o, 0);
    check_eq("rst_blink", blink_o, 0);
    check_eq("rst_pulses", {inc_hour_o, inc_min_o, clr_sec_o}, 0);
    cyc(20);
    check_eq("idle_run", run_o, 1);
    check_eq("idle_sel", sel_o, 0);
    check_eq("idle_pulses", n_hour + n_min + n_clr, 0);

    // 3-cycle glitch must not pass the 4-cycle debouncer
    mode_btn_i = 1'b1;
    cyc(3);
    mode_btn_i = 1'b0;
    cyc(10);
    check_eq("glitch_sel", sel_o, 0);
    check_eq("glitch_run", run_o, 1);

    // Held 4 cycles: debounced edge after 4th edge, outputs one edge later
    mode_btn_i = 1'b1;
    cyc(4);
    check_eq("mode_pre_sel", sel_o, 0);
    cyc(1);
    check_eq("mode_sel_hour", sel_o, 1);
    check_eq("mode_run_hour", run_o, 0);
    check_eq("mode_blink_entry", blink_o, 1);
    mode_btn_i = 1'b0;
    cyc(6);

    h0 = n_hour;
    m0 = n_min;
    repeat (3) press_inc();
    check_eq("hour_incs", n_hour - h0, 3);
    check_eq("hour_no_min", n_min - m0, 0);
    check_eq("hour_blink", blink_o, 1);

    press_mode();
    check_eq("sel_min", sel_o, 2);
    m0 = n_min;
    press_inc();
    check_eq("min_inc", n_min - m0, 1);
    c0 = n_clr;
    press_mode();
    check_eq("back_sel", sel_o, 0);
    check_eq("back_run", run_o, 1);
    check_eq("back_clr", n_clr - c0, 1);

    // Blink toggling, then inactivity timeout from SET_MIN
    press_mode();
    check_eq("blink_entry", blink_o, 1);
    tick1();
    check_eq("blink_tog0", blink_o, 0);
    tick1();
    check_eq("blink_tog1", blink_o, 1);
    press_mode();
    check_eq("to_sel_min", sel_o, 2);
    c0 = n_clr;
    repeat (4) tick1();
    cyc(2);
    check_eq("to_4ticks", sel_o, 2);
    tick1();
    cyc(2);
    check_eq("to_5ticks", sel_o, 0);
    check_eq("to_run", run_o, 1);
    check_eq("to_no_clr", n_clr - c0, 0);

    // INC press event coincides with the 4th tick: press clears the count
    press_mode();
    press_mode();
    check_eq("rs_sel_min", sel_o, 2);
    m0 = n_min;
    repeat (3) tick1();
    inc_btn_i = 1'b1;
    cyc(4);
    tick_i = 1'b1;
    cyc(1);
    tick_i = 1'b0;
    cyc(2);
    inc_btn_i = 1'b0;
    cyc(6);
    check_eq("rs_inc", n_min - m0, 1);
    repeat (4) tick1();
    cyc(2);
    check_eq("rs_4ticks", sel_o, 2);
    tick1();
    cyc(2);
    check_eq("rs_5ticks", sel_o, 0);

    // Simultaneous MODE and INC in SET_HOUR
    press_mode();
    h0 = n_hour;
    m0 = n_min;
    mode_btn_i = 1'b1;
    inc_btn_i  = 1'b1;
    cyc(6);
    mode_btn_i = 1'b0;
    inc_btn_i  = 1'b0;
    cyc(6);
    check_eq("simul_sel", sel_o, 2);
    check_eq("simul_no_hour", n_hour - h0, 0);
    check_eq("simul_no_min", n_min - m0, 0);
    press_mode();

    // INC ignored in RUN
    h0 = n_hour;
    m0 = n_min;
    press_inc();
    check_eq("run_inc_sel", sel_o, 0);
    check_eq("run_inc_none", (n_hour - h0) + (n_min - m0), 0);

    // Reset in the press-event cycle drops the pending pulse
    press_mode();
    h0 = n_hour;
    inc_btn_i = 1'b1;
    cyc(4);
    rst_i = 1'b1;
    cyc(2);
    inc_btn_i = 1'b0;
    cyc(5);
    rst_i = 1'b0;
    cyc(2);
    check_eq("rst_abort_pulse", n_hour - h0, 0);
    check_eq("rst_abort_sel", sel_o, 0);
    check_eq("rst_abort_run", run_o, 1);
    check_eq("rst_abort_blink", blink_o, 0);

    // INC held through 5 ticks in SET_HOUR
    press_mode();
    h0 = n_hour;
    inc_btn_i = 1'b1;
    cyc(6);
    repeat (5) begin
      tick1();
      cyc(1);
    end
`ifdef AUTOREPEAT_EN
    check_eq("hold_blink", blink_o, 1);
`else
    check_eq("hold_blink", blink_o, 0);
`endif
    inc_btn_i = 1'b0;
    cyc(6);
`ifdef AUTOREPEAT_EN
    check_eq("hold_pulses", n_hour - h0, 4);
    check_eq("hold_sel", sel_o, 1);
`else
    check_eq("hold_pulses", n_hour - h0, 1);
    check_eq("hold_sel", sel_o, 0);
`endif

    check_eq("pulse_exclusive", n_multi, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
